// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature encoder decoder.
// Gray position maps {A,B} onto a 0..3 ring so that direction reduces to a 2-bit difference.
package quad_pkg;

    localparam int unsigned COUNT_W_DEF = 32;
    localparam int unsigned ERR_CNT_W   = 8;

    typedef enum logic [2:0] {
        StInit,
        St00,
        St01,
        St11,
        St10
    } dec_state_e;

    function automatic dec_state_e ab_to_state(input logic [1:0] ab);
        dec_state_e s;
        unique case (ab)
            2'b00:   s = St00;
            2'b01:   s = St01;
            2'b11:   s = St11;
            default: s = St10;
        endcase
        return s;
    endfunction

    function automatic logic [1:0] state_to_ab(input dec_state_e s);
        logic [1:0] ab;
        case (s)
            St01:    ab = 2'b01;
            St11:    ab = 2'b11;
            St10:    ab = 2'b10;
            default: ab = 2'b00;
        endcase
        return ab;
    endfunction

    // 00->0, 01->1, 11->2, 10->3
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

endpackage

// File: rtl/glitch_filter.sv
// Single-bit 2-flop synchronizer followed by a run-length glitch filter.
// The filtered value follows the synchronized one once the difference has persisted FILTER_LEN cycles.
module glitch_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic settled
);

    logic       sync1_q;
    logic       sync2_q;
    logic       filt_q;
    logic       filt_d;
    logic [3:0] run_q;
    logic [3:0] run_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            run_q   <= 4'd0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        filt_d = filt_q;
        run_d  = 4'd0;
        if (sync2_q != filt_q) begin
            if (run_q == 4'(FILTER_LEN)) begin
                filt_d = sync2_q;
            end else begin
                run_d = run_q + 4'd1;
            end
        end
    end

    assign dout    = filt_q;
    // Whole chain agrees: nothing in flight that could still move the filtered value.
    assign settled = (sync1_q == sync2_q) && (sync2_q == filt_q);

endmodule

// File: rtl/quad_encoder_decoder.sv
// Quadrature encoder decoder: filtered A/B channels drive a 4-state gray decoder that
// maintains a signed angle count, direction, step pulse and illegal-transition error state.
module quad_encoder_decoder
    import quad_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned COUNT_W    = COUNT_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enc_a,
    input  logic                        enc_b,
    input  logic                        clear,
    output logic signed [COUNT_W-1:0]   angle,
    output logic                        dir,
    output logic                        step,
    output logic                        err,
    output logic [ERR_CNT_W-1:0]        err_cnt
);

    logic a_filt;
    logic b_filt;
    logic a_settled;
    logic b_settled;

    glitch_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filt_a (
        .clk     (clk),
        .reset   (reset),
        .din     (enc_a),
        .dout    (a_filt),
        .settled (a_settled)
    );

    glitch_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filt_b (
        .clk     (clk),
        .reset   (reset),
        .din     (enc_b),
        .dout    (b_filt),
        .settled (b_settled)
    );

    dec_state_e           state_q;
    dec_state_e           state_d;
    logic [COUNT_W-1:0]   angle_q;
    logic [COUNT_W-1:0]   angle_d;
    logic                 dir_q;
    logic                 dir_d;
    logic                 step_q;
    logic                 step_d;
    logic                 err_q;
    logic                 err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [ERR_CNT_W-1:0] err_cnt_d;
    logic [1:0]           warm_q;
    logic [1:0]           warm_d;

    logic [1:0] ab;
    logic [1:0] delta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StInit;
            angle_q   <= '0;
            dir_q     <= 1'b0;
            step_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            warm_q    <= 2'd0;
        end else begin
            state_q   <= state_d;
            angle_q   <= angle_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            warm_q    <= warm_d;
        end
    end

    assign ab    = {a_filt, b_filt};
    assign delta = gray_pos(ab) - gray_pos(state_to_ab(state_q));

    always_comb begin
        state_d   = state_q;
        angle_d   = angle_q;
        dir_d     = dir_q;
        step_d    = 1'b0;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        warm_d    = warm_q;

        if (state_q == StInit) begin
            // Wait for the synchronizers to fill and both filters to settle, so the
            // reset-time zeros never register as a first transition.
            if (warm_q != 2'd2) begin
                warm_d = warm_q + 2'd1;
            end else if (a_settled && b_settled) begin
                state_d = ab_to_state(ab);
            end
        end else begin
            state_d = ab_to_state(ab);
            unique case (delta)
                2'd0: ;
                2'd1: begin
                    angle_d = angle_q + COUNT_W'(1);
                    dir_d   = 1'b1;
                    step_d  = 1'b1;
                end
                2'd3: begin
                    angle_d = angle_q - COUNT_W'(1);
                    dir_d   = 1'b0;
                    step_d  = 1'b1;
                end
                2'd2: begin
                    err_d = 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                    end
                end
            endcase
        end

        if (clear) begin
            angle_d   = '0;
            err_d     = 1'b0;
            err_cnt_d = '0;
            step_d    = 1'b0;
        end
    end

    assign angle   = angle_q;
    assign dir     = dir_q;
    assign step    = step_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_quad_encoder_decoder.sv
// Directed bench for quad_encoder_decoder; a 4-bit-counter instance shares the stimulus
// to exercise signed wrap-around without a 2^31-step run.
module tb_quad_encoder_decoder;
    import quad_pkg::*;

    logic        clk;
    logic        reset;
    logic        enc_a;
    logic        enc_b;
    logic        clear;
    logic [31:0] angle;
    logic        dir;
    logic        step;
    logic        err;
    logic [7:0]  err_cnt;
    logic [3:0]  angle_n;
    logic        dir_n;
    logic        step_n;
    logic        err_n;
    logic [7:0]  err_cnt_n;

    int pass_cnt;
    int total_cnt;
    int step_seen;
    int lat;

    logic [1:0] fwd_seq [4];

    quad_encoder_decoder #(
        .FILTER_LEN (4),
        .COUNT_W    (32)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .clear   (clear),
        .angle   (angle),
        .dir     (dir),
        .step    (step),
        .err     (err),
        .err_cnt (err_cnt)
    );

    quad_encoder_decoder #(
        .FILTER_LEN (4),
        .COUNT_W    (4)
    ) dut_n (
        .clk     (clk),
        .reset   (reset),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .clear   (clear),
        .angle   (angle_n),
        .dir     (dir_n),
        .step    (step_n),
        .err     (err_n),
        .err_cnt (err_cnt_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (step) step_seen++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        step_seen = 0;
        fwd_seq[0] = 2'b10;
        fwd_seq[1] = 2'b00;
        fwd_seq[2] = 2'b01;
        fwd_seq[3] = 2'b11;

        // Reset with A=B=1 held
        reset = 1'b0;
        clear = 1'b0;
        enc_a = 1'b1;
        enc_b = 1'b1;
        ticks(3);
        check("rst_angle", angle, 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(StInit));
        reset = 1'b1;
        step_seen = 0;
        ticks(12);
        check("init_state", 32'(dut.state_q), 32'(St11));
        check("init_angle", angle, 32'd0);
        check("init_err", 32'(err), 32'd0);
        check("init_no_step", 32'(step_seen), 32'd0);

        // 32 forward edges, 20 clocks per phase, step exactly FILTER_LEN+3 after the sample
        step_seen = 0;
        for (int c = 0; c < 8; c++) begin
            for (int p = 0; p < 4; p++) begin
                {enc_a, enc_b} = fwd_seq[p];
                lat = 0;
                for (int t = 1; t <= 20; t++) begin
                    tick();
                    if (step && lat == 0) lat = t;
                end
                check("fwd_latency", 32'(lat), 32'd8);
                if (c * 4 + p + 1 == 7) check("narrow_at_7", 32'(angle_n), 32'h7);
                if (c * 4 + p + 1 == 8) check("narrow_wrap_8", 32'(angle_n), 32'h8);
            end
        end
        check("fwd_angle", angle, 32'd32);
        check("fwd_dir", 32'(dir), 32'd1);
        check("fwd_pulses", 32'(step_seen), 32'd32);

        // Reset preload then one reverse edge: 11 -> 01
        reset = 1'b0;
        #1;
        check("async_rst_angle", angle, 32'd0);
        check("async_rst_dir", 32'(dir), 32'd0);
        ticks(2);
        reset = 1'b1;
        ticks(12);
        check("pre_rev_angle", angle, 32'd0);
        {enc_a, enc_b} = 2'b01;
        ticks(12);
        check("rev_wrap_angle", angle, 32'hFFFF_FFFF);
        check("rev_dir", 32'(dir), 32'd0);
        check("narrow_rev_wrap", 32'(angle_n), 32'hF);

        // 3-cycle glitch on A is rejected
        step_seen = 0;
        enc_a = 1'b1;
        ticks(3);
        enc_a = 1'b0;
        ticks(12);
        check("glitch_angle", angle, 32'hFFFF_FFFF);
        check("glitch_err", 32'(err), 32'd0);
        check("glitch_no_step", 32'(step_seen), 32'd0);

        // 300 double-bit toggles
        step_seen = 0;
        for (int i = 0; i < 300; i++) begin
            {enc_a, enc_b} = ~{enc_a, enc_b};
            ticks(8);
            if (i == 0) begin
                check("ill_first_err", 32'(err), 32'd1);
                check("ill_first_cnt", 32'(err_cnt), 32'd1);
            end
        end
        check("ill_angle", angle, 32'hFFFF_FFFF);
        check("ill_dir", 32'(dir), 32'd0);
        check("ill_err", 32'(err), 32'd1);
        check("ill_err_cnt_sat", 32'(err_cnt), 32'd255);
        check("ill_no_step", 32'(step_seen), 32'd0);
        check("narrow_err_cnt_sat", 32'(err_cnt_n), 32'd255);

        // clear coincident with a forward step 01 -> 11
        {enc_a, enc_b} = 2'b11;
        ticks(7);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_angle", angle, 32'd0);
        check("clr_step", 32'(step), 32'd0);
        check("clr_err", 32'(err), 32'd0);
        check("clr_err_cnt", 32'(err_cnt), 32'd0);
        ticks(4);
        {enc_a, enc_b} = 2'b10;
        ticks(10);
        check("post_clr_angle", angle, 32'd1);
        check("post_clr_dir", 32'(dir), 32'd1);

        // Reset mid-sequence, between clock edges
        {enc_a, enc_b} = 2'b00;
        ticks(3);
        #3;
        reset = 1'b0;
        #1;
        check("mid_rst_angle", angle, 32'd0);
        check("mid_rst_dir", 32'(dir), 32'd0);
        check("mid_rst_step", 32'(step), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        ticks(2);
        reset = 1'b1;
        step_seen = 0;
        ticks(12);
        check("rel_angle", angle, 32'd0);
        check("rel_no_step", 32'(step_seen), 32'd0);
        {enc_a, enc_b} = 2'b01;
        ticks(10);
        check("resume_angle", angle, 32'd1);
        check("resume_dir", 32'(dir), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/quad_encoder_decoder.md
QUAD_ENCODER_DECODER -- requirements
Module: quad_encoder_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 4: consecutive stable cycles required before a synchronized encoder input is accepted; legal range 1..15.
REQ-002 Parameter COUNT_W, default 32: angle counter width, matching the 32-bit angle input of the downstream speed stage.
REQ-003 Port clk  input  1: single clock for all logic.
REQ-004 Port reset  input  1: asynchronous, active-low reset.
REQ-005 Port enc_a  input  1: raw encoder channel A, asynchronous to clk.
REQ-006 Port enc_b  input  1: raw encoder channel B, asynchronous to clk.
REQ-007 Port clear  input  1: synchronous, active-high zeroing of angle and error state.
REQ-008 Port angle  output  COUNT_W: signed two's-complement position count in quadrature edges.
REQ-009 Port dir  output  1: direction of last valid step; 1 = forward, 0 = reverse.
REQ-010 Port step  output  1: one-cycle pulse on each valid count change.
REQ-011 Port err  output  1: sticky flag set on an illegal transition.
REQ-012 Port err_cnt  output  8: count of illegal transitions, saturating at 255.

Function
REQ-013 Each of enc_a and enc_b SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Glitch filter: the filtered value SHALL take the synchronized value only after that value has differed from the filtered value for FILTER_LEN consecutive cycles; any return to equality restarts the run counter at 0.
REQ-015 Decoder states: INIT, S00, S01, S11, S10, where the state name gives the filtered {A,B}.
REQ-016 INIT is entered on reset; on the first cycle after reset release, the state SHALL load the current filtered {A,B} with no count change, no step pulse and no error.
REQ-017 Forward sequence S00->S01->S11->S10->S00: angle +1, dir=1, step=1.
REQ-018 Reverse sequence (the inverse of REQ-017): angle -1, dir=0, step=1.
REQ-019 A change of both bits in one cycle (S00<->S11, S01<->S10) SHALL leave angle and dir unchanged, keep step=0, set err, increment err_cnt, and move the state to the new value.
REQ-020 angle SHALL wrap modulo 2^COUNT_W: 0x7FFFFFFF+1 -> 0x80000000 and 0x00000000-1 -> 0xFFFFFFFF.
REQ-021 err_cnt SHALL saturate at 255; further illegal transitions hold it at 255.
REQ-022 Latency: a clean input edge sampled at rising edge k SHALL appear on angle/step at rising edge k+FILTER_LEN+3.
REQ-023 When clear and a valid step occur in the same cycle, clear SHALL win: angle=0, err=0, err_cnt=0, step=0; the decoder state still tracks the new input.
REQ-024 clear SHALL NOT reset the synchronizers, the filters, the decoder state or dir.

Reset
REQ-025 While reset is low: angle=0, dir=0, step=0, err=0, err_cnt=0, synchronizers and filtered values=0, filter run counters=0, state=INIT.
REQ-026 Assertion of reset mid-operation SHALL take effect immediately, without waiting for a clock edge; counting resumes from 0 via INIT after release.

Structure
REQ-027 Package quad_pkg SHALL hold the decoder state enum, COUNT_W default and ERR_CNT_W=8.
REQ-028 Sub-module glitch_filter (single bit, synchronizer plus run-length filter, parameter FILTER_LEN) SHALL be instantiated once per channel.
REQ-029 angle SHALL drive the downstream speed stage directly, with no additional register.

Verification
REQ-030 Reset with A=B=1, release, hold inputs -> state S11, angle=0, err=0, no step.
REQ-031 Drive 8 forward quadrature cycles (32 edges), 20 clk per phase -> angle=32, dir=1, 32 step pulses, each exactly FILTER_LEN+3 cycles after its edge.
REQ-032 Preload angle to 0 by reset, then one reverse edge -> angle=0xFFFFFFFF, dir=0; with a forced counter at 0x7FFFFFFF, one forward edge -> 0x80000000.
REQ-033 Pulse A high for 3 cycles with FILTER_LEN=4 -> no change in angle, step or err.
REQ-034 Toggle A and B together 300 times -> angle unchanged, err=1, err_cnt=255.
REQ-035 Assert clear in the same cycle as a forward step, then assert reset mid-sequence -> angle=0 and err_cnt=0 after clear; all outputs 0 immediately on reset, with no clock edge needed.
